// File: rtl/imem_loader.sv
// imem_loader -- write side of the instruction memory.
//
// Takes a length-prefixed byte stream over a valid/ready handshake:
//   LEN_LO, LEN_HI (16-bit word count), then 4*LEN payload bytes, LSB first.
// Bytes are packed little-endian into 32-bit words, and each completed word
// is written to imem through we/waddr/wdata. The CPU is held in reset until
// the load completes.
//
// Optional feature macro: CHECKSUM_EN
//   When defined, one trailing byte follows the payload. It must equal the
//   8-bit XOR of all payload bytes, otherwise the load ends in ERR.
//
// Parameters:
//   N_ADDR    word-address width; imem depth = 1<<N_ADDR words
//
// Ports:
//   clock     system clock, all state on rising edge
//   nReset    asynchronous active-low reset
//   start     1-cycle pulse, begins a load (honoured in IDLE/DONE/ERR only)
//   rx_data   incoming byte
//   rx_valid  rx_data valid
//   rx_ready  loader can accept a byte
//   we        imem write enable, 1-cycle pulse per word
//   waddr     imem word address
//   wdata     imem write data
//   cpu_hold  1 = keep CPU in reset
//   done      load completed OK (level)
//   err       load failed (level)
module imem_loader #(
    parameter int unsigned N_ADDR = 6
) (
    input  logic              clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we,
    output logic [N_ADDR-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
`ifdef CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t POST_DATA = CSUM;
`else
    localparam state_t POST_DATA = DONE;
`endif

    localparam logic [16:0] MAX_LEN = 17'(64'd1 << N_ADDR);

    state_t      state, state_nx;
    logic [7:0]  len_lo;
    logic [15:0] len_words;
    logic [15:0] wcnt;
    logic [1:0]  bidx;
    logic [15:0] len_full;
    logic        acc;
    logic        last_word;
    logic        load_begin;
`ifdef CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign len_full   = {rx_data, len_lo};
    assign acc        = rx_valid & rx_ready;
    // wcnt counts words already completed before the current one.
    assign last_word  = (wcnt == len_words - 16'd1);
    assign load_begin = start && (state == IDLE || state == DONE || state == ERR);

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rx_ready = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        cpu_hold = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nx = LEN0;
            end
            LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = LEN1;
            end
            LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if ({1'b0, len_full} > MAX_LEN) state_nx = ERR;
                    else if (len_full == 16'd0)     state_nx = POST_DATA;
                    else                            state_nx = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                // Leave on the final byte; its write pulse lands in the
                // first cycle of the following state.
                if (rx_valid && bidx == 2'd3 && last_word) state_nx = POST_DATA;
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = (rx_data == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nx = LEN0;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_nx = LEN0;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            len_lo    <= '0;
            len_words <= '0;
            wcnt      <= '0;
            bidx      <= '0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            we <= 1'b0;
            if (we) waddr <= waddr + {{(N_ADDR-1){1'b0}}, 1'b1};
            if (state == LEN0 && acc) len_lo    <= rx_data;
            if (state == LEN1 && acc) len_words <= len_full;
            if (state == DATA && acc) begin
                case (bidx)
                    2'd0:    wdata[7:0]   <= rx_data;
                    2'd1:    wdata[15:8]  <= rx_data;
                    2'd2:    wdata[23:16] <= rx_data;
                    default: wdata[31:24] <= rx_data;
                endcase
                bidx <= bidx + 2'd1;
`ifdef CHECKSUM_EN
                csum <= csum ^ rx_data;
`endif
                if (bidx == 2'd3) begin
                    we   <= 1'b1;
                    wcnt <= wcnt + 16'd1;
                end
            end
            if (load_begin) begin
                waddr <= '0;
                bidx  <= '0;
                wcnt  <= '0;
`ifdef CHECKSUM_EN
                csum  <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- self-checking bench for imem_loader.
// Builds byte streams, predicts the imem writes and final status from the
// stream format alone, and compares against the writes seen on the port.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned N_ADDR = 6;
    localparam int unsigned DEPTH  = 1 << N_ADDR;

    logic              clock = 1'b0;
    logic              nReset;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we;
    logic [N_ADDR-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [N_ADDR-1:0] obs_addr[$];
    logic [31:0]       obs_data[$];

    always #5 clock = ~clock;

    imem_loader #(.N_ADDR(N_ADDR)) dut (
        .clock    (clock),
        .nReset   (nReset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always @(negedge clock) begin
        if (we) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xor_payload(input logic [7:0] s[$]);
        logic [7:0] x = 8'h00;
        for (int i = 2; i < s.size(); i++) x ^= s[i];
        return x;
    endfunction

    task automatic make_stream(input int len, input bit bad_csum, output logic [7:0] s[$]);
        s = {};
        s.push_back(8'(len));
        s.push_back(8'(len >> 8));
        if (len <= int'(DEPTH)) begin
            for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom));
`ifdef CHECKSUM_EN
            s.push_back(xor_payload(s) ^ (bad_csum ? 8'h5A : 8'h00));
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int n;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) begin
            @(negedge clock);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("rx_ready_timeout", rx_ready, 1);
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] s[$], input int maxgap, input int start_at,
                            input string tag);
        int         len;
        bit         ok;
        int         n;
        logic [N_ADDR-1:0] exp_addr[$];
        logic [31:0]       exp_data[$];
        len = int'(s[0]) | (int'(s[1]) << 8);
        if (len > int'(DEPTH)) begin
            ok = 1'b0;
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_addr.push_back(N_ADDR'(i));
                exp_data.push_back({s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]});
            end
            ok = 1'b1;
`ifdef CHECKSUM_EN
            begin
                logic [7:0] x = 8'h00;
                for (int i = 0; i < 4 * len; i++) x ^= s[2+i];
                ok = (s[s.size()-1] == x);
            end
`endif
        end
        obs_addr = {};
        obs_data = {};
        pulse_start();
        for (int i = 0; i < s.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(s[i], maxgap);
        end
        n = 0;
        while (!(done || err) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, ".finished"}, done || err, 1);
        repeat (2) @(negedge clock);
        check({tag, ".nwrites"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s.waddr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s.wdata[%0d]", tag, i), obs_data[i], exp_data[i]);
        end
        check({tag, ".done"}, done, ok);
        check({tag, ".err"}, err, !ok);
        check({tag, ".cpu_hold"}, cpu_hold, !ok);
        check({tag, ".rx_ready"}, rx_ready, 0);
        if (ok) check({tag, ".final_waddr"}, waddr, N_ADDR'(len));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".rx_ready"}, rx_ready, 0);
        check({tag, ".we"}, we, 0);
        check({tag, ".cpu_hold"}, cpu_hold, 1);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".waddr"}, waddr, 0);
        check({tag, ".wdata"}, wdata, 0);
    endtask

    initial begin
        logic [7:0] s[$];

        // T1: reset held with random inputs
        nReset   = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (6) begin
            @(negedge clock);
            start    = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
        end
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        start    = 1'b0;
        rx_valid = 1'b0;
        nReset   = 1'b1;
        repeat (2) @(negedge clock);

        // T2 / T3: fixed stream, then the same with random gaps
        s = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef CHECKSUM_EN
        s.push_back(xor_payload(s));
`endif
        run_load(s, 0, -1, "basic");
        run_load(s, 3, -1, "gaps");

        // Random lengths and gaps
        for (int k = 0; k < 4; k++) begin
            make_stream(int'($urandom_range(8, 1)), 1'b0, s);
            run_load(s, k, -1, $sformatf("rand%0d", k));
        end

        // T4: oversize lengths
        s = {8'h41, 8'h00};
        run_load(s, 0, -1, "oversize41");
        s = {8'h00, 8'h01};
        run_load(s, 1, -1, "oversize100");

        // T5: full memory and zero length
        make_stream(int'(DEPTH), 1'b0, s);
        run_load(s, 0, -1, "full");
        make_stream(0, 1'b0, s);
        run_load(s, 0, -1, "zero");

        // T6: reset mid-load discards the partial word
        obs_addr = {};
        obs_data = {};
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        nReset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clock);
        check("midreset.nwrites", obs_addr.size(), 0);
        nReset = 1'b1;
        make_stream(3, 1'b0, s);
        run_load(s, 1, -1, "after_reset");

        // T6: start pulse in the middle of the payload is ignored
        make_stream(3, 1'b0, s);
        run_load(s, 0, 7, "start_busy");

`ifdef CHECKSUM_EN
        make_stream(3, 1'b1, s);
        run_load(s, 1, -1, "bad_csum");
        make_stream(2, 1'b0, s);
        run_load(s, 0, -1, "after_bad_csum");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
